sum_n_nos: RTL and testbench
============================

// Module: sum_n_nos
// PURPOSE
//   Computes S = 1+2+...+N for a small unsigned N accepted over a valid/ready handshake.
//   Presents S with sum_valid and holds it until the consumer acknowledges with ack.
//   Standalone arithmetic leaf block; one transaction in flight at a time.
// PARAMETERS
//   N_W    3  width of N_in
//   SUM_W  5  width of sum; must hold (2^N_W-1)*2^N_W/2 (28 for N_W=3)
// PORTS
//   clk        input   1      single clock, all state updates on rising edge
//   reset      input   1      asynchronous, active-high reset
//   N_valid    input   1      N_in is valid this cycle
//   N_in       input   N_W    unsigned operand N (0..7 by default)
//   ack        input   1      consumer has taken sum; frees the block
//   ready      output  1      block idle, will accept N_in
//   sum_valid  output  1      sum holds a completed result
//   sum        output  SUM_W  result N*(N+1)/2
// BEHAVIOUR
//   Reset: one clock; reset is asynchronous and active-high.
//   - While reset is high: state=IDLE, ready=1, sum_valid=0, sum=0, internal acc/cnt=0.
//   States: IDLE -> CALC -> DONE -> IDLE.
//   - ready = (state==IDLE), decoded combinationally from state.
//   - sum_valid = (state==DONE), decoded combinationally from state.
//   IDLE:
//   - On an edge with N_valid=1, go to CALC, load cnt=N_in, acc=0.
//   - Otherwise stay in IDLE.
//   CALC, each edge:
//   - If cnt==0: sum<=acc, go to DONE.
//   - Else: acc<=acc+cnt, cnt<=cnt-1.
//   Latency: sum_valid rises N+1 edges after the accept edge (N=0 -> 1 edge, N=7 -> 8 edges).
//   DONE: sum and sum_valid held stable until ack=1 is sampled; then go to IDLE.
//   - sum keeps its last value in IDLE; only sum_valid qualifies it.
//   Boundary conditions:
//   - N_valid while not IDLE: ignored, no queuing.
//   - N_valid held for several cycles: exactly one acceptance.
//   - ack outside DONE: ignored.
//   - ack and N_valid both high in DONE: ack returns to IDLE; N_valid is ignored that edge.
//     The next edge may accept a new N (no same-cycle turnaround).
//   - N=0 -> sum=0.
//   - Maximum N: no overflow given the SUM_W rule; arithmetic is unsigned.
//   - acc is SUM_W wide and cnt is N_W wide.
//   - Reset asserted mid-CALC or mid-DONE: immediate return to reset state; the result is lost.
// CONFIGURATION
//   SUM_N_CLOSED_FORM_EN defined:
//   - CALC lasts exactly one edge; sum<=(N*(N+1))>>1 is computed from a registered copy of N.
//   - sum_valid rises 1 edge after accept for every N.
//   SUM_N_CLOSED_FORM_EN undefined:
//   - Iterative adder as described in BEHAVIOUR; no multiplier.
//   Handshake and reset behaviour are identical in both builds.
// STRUCTURE
//   Package sum_n_pkg:
//   - typedef enum logic [1:0] {IDLE, CALC, DONE} state_t.
//   - Default N_W/SUM_W localparams.
//   - Function min_sum_w(n_w) for parameter checking.
//   Sub-module sum_n_accum:
//   - Holds acc/cnt and the (optional) closed-form datapath.
//   - Driven by load/step strobes from the FSM in sum_n_nos.
//   Elaboration check: SUM_W >= min_sum_w(N_W).
// TESTING
//   1. Reset pulse -> ready=1, sum_valid=0, sum=0 during and after reset.
//   2. N_in=0, N_valid held 2 cycles -> one acceptance, ready drops; sum_valid=1 with sum=0;
//      ack -> ready=1 next edge.
//   3. N_in=7 -> sum=28 after 8 edges (1 edge with closed form); holds while ack=0 for 10 cycles.
//   4. N_in=3 then N_in=5 back-to-back via ack -> sums 6 then 15; no overlap.
//   5. Reset asserted in CALC for N=6 -> immediate IDLE, sum_valid never rises.
//   6. ack pulsed in IDLE/CALC -> no effect; sweep N=0..7 against N*(N+1)/2.

Source files
------------

// File: rtl/sum_n_pkg.sv
// Shared types, default widths and the sum-width helper for the sum_n_nos block.
package sum_n_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int N_W_DEF   = 3;
  localparam int SUM_W_DEF = 5;

  // Bits needed to hold 1+2+...+(2^n_w-1) without overflow.
  function automatic int min_sum_w(input int n_w);
    longint max_sum;
    max_sum = (((longint'(1) << n_w) - 1) * (longint'(1) << n_w)) / 2;
    return $clog2(max_sum + 1);
  endfunction

endpackage

// File: rtl/sum_n_accum.sv
// Datapath for sum_n_nos: iterative acc/cnt adder, or a one-step closed form when
// SUM_N_CLOSED_FORM_EN is defined. Driven by load/step strobes from the FSM.
module sum_n_accum
  import sum_n_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [N_W-1:0]   i_n,
  output logic             o_done,
  output logic [SUM_W-1:0] o_sum
);

`ifdef SUM_N_CLOSED_FORM_EN
  // One extra bit so N*(N+1) fits before the halving shift.
  localparam int P_W = SUM_W + 1;

  logic [N_W-1:0]   r_n;
  logic [SUM_W-1:0] r_sum;
  logic [P_W-1:0]   w_prod;

  assign w_prod = P_W'(r_n) * (P_W'(r_n) + P_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n   <= '0;
      r_sum <= '0;
    end else begin
      if (i_load) r_n <= i_n;
      if (i_step) r_sum <= w_prod[P_W-1:1];
    end
  end

  assign o_done = 1'b1;
`else
  logic [SUM_W-1:0] r_acc;
  logic [N_W-1:0]   r_cnt;
  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sum <= '0;
    end else if (i_load) begin
      r_cnt <= i_n;
      r_acc <= '0;
    end else if (i_step) begin
      if (r_cnt == '0) begin
        r_sum <= r_acc;
      end else begin
        r_acc <= r_acc + SUM_W'(r_cnt);
        r_cnt <= r_cnt - N_W'(1);
      end
    end
  end

  assign o_done = (r_cnt == '0);
`endif

  assign o_sum = r_sum;

endmodule

// File: rtl/sum_n_nos.sv
// S = 1+..+N over valid/ready; result held with sum_valid until ack. Latency N+1 edges,
// or 1 edge with SUM_N_CLOSED_FORM_EN. Accepts only in IDLE; one transaction in flight.
module sum_n_nos
  import sum_n_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             N_valid,
  input  logic [N_W-1:0]   N_in,
  input  logic             ack,
  output logic             ready,
  output logic             sum_valid,
  output logic [SUM_W-1:0] sum
);

  generate
    if (SUM_W < min_sum_w(N_W)) begin : g_bad_sum_w
      $error("sum_n_nos: SUM_W too narrow for N_W");
    end
  endgenerate

  state_t r_state;
  state_t w_next;
  logic   w_load;
  logic   w_step;
  logic   w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (N_valid) w_next = CALC;
      CALC:    if (w_done)  w_next = DONE;
      DONE:    if (ack)     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = (r_state == IDLE);
    sum_valid = (r_state == DONE);
    w_load    = (r_state == IDLE) && N_valid;
    w_step    = (r_state == CALC);
  end

  sum_n_accum #(
    .N_W   (N_W),
    .SUM_W (SUM_W)
  ) u_accum (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_n    (N_in),
    .o_done (w_done),
    .o_sum  (sum)
  );

endmodule

// File: tb/tb_sum_n_nos.sv
// Scoreboard bench for sum_n_nos: stimulus pushes expected sum/latency, a negedge monitor checks.
module tb_sum_n_nos;

  logic       clk;
  logic       reset;
  logic       N_valid;
  logic [2:0] N_in;
  logic       ack;
  logic       ready;
  logic       sum_valid;
  logic [4:0] sum;

  typedef struct {
    int sum;
    int acc_cyc;
    int lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic prev_sv = 1'b0;
  int   held  = 0;

  sum_n_nos dut (
    .clk       (clk),
    .reset     (reset),
    .N_valid   (N_valid),
    .N_in      (N_in),
    .ack       (ack),
    .ready     (ready),
    .sum_valid (sum_valid),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: arithmetic series and the documented latency.
  function automatic exp_t model(input int n, input int c);
    exp_t e;
    e.sum     = n * (n + 1) / 2;
    e.acc_cyc = c;
`ifdef SUM_N_CLOSED_FORM_EN
    e.lat     = 1;
`else
    e.lat     = n + 1;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (sum_valid && !prev_sv) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum", 32'(sum), e.sum);
          check("latency", cyc - e.acc_cyc, e.lat);
        end
        held = int'(sum);
      end else if (sum_valid && prev_sv) begin
        check("sum_hold", 32'(sum), held);
      end
    end
    prev_sv = sum_valid;
  end

  task automatic do_txn(input logic [2:0] n, input int hold, input int ack_dly,
                        input bit ack_early, input bit nv_with_ack);
    int t;
    @(negedge clk);
    t = 0;
    while (!ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 0, 1);
    N_in    = n;
    N_valid = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(model(int'(n), cyc));
    @(negedge clk);
    check("ready_drop", 32'(ready), 0);
    repeat (hold) begin
      N_in = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    N_valid = 1'b0;
    if (ack_early) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
    t = 0;
    while (!sum_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("valid_seen", 32'(sum_valid), 1);
    repeat (ack_dly) @(negedge clk);
    check("valid_held", 32'(sum_valid), 1);
    ack = 1'b1;
    if (nv_with_ack) begin
      N_valid = 1'b1;
      N_in    = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    ack     = 1'b0;
    N_valid = 1'b0;
    check("ready_after_ack", 32'(ready), 1);
    check("valid_after_ack", 32'(sum_valid), 0);
  endtask

  initial begin
    reset   = 1'b1;
    N_valid = 1'b0;
    N_in    = '0;
    ack     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_valid", 32'(sum_valid), 0);
    check("rst_sum", 32'(sum), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 1);
    check("post_rst_valid", 32'(sum_valid), 0);
    check("post_rst_sum", 32'(sum), 0);

    do_txn(3'd0, 1, 0, 1'b0, 1'b0);
    do_txn(3'd7, 0, 10, 1'b0, 1'b0);
    do_txn(3'd3, 0, 0, 1'b0, 1'b1);
    do_txn(3'd5, 0, 0, 1'b0, 1'b0);

    // Reset while CALC: result must be lost and never surface.
    @(negedge clk);
    N_in    = 3'd6;
    N_valid = 1'b1;
    @(posedge clk);
    #1;
    N_valid = 1'b0;
    reset   = 1'b1;
    #1;
    check("midcalc_ready", 32'(ready), 1);
    check("midcalc_valid", 32'(sum_valid), 0);
    check("midcalc_sum", 32'(sum), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midcalc_no_valid", 32'(sum_valid), 0);

    for (int n = 0; n < 8; n++) do_txn(3'(n), 0, 1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int h;
      h = $urandom_range(0, 3);
      do_txn(3'($urandom_range(0, 7)), h, $urandom_range(0, 4),
             (h == 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
